// File: rtl/nco_quad_gen.sv
// Quadrature NCO: 20-bit phase accumulator driving a quarter-wave sine ROM.
// A four-stage pipeline delivers sin/cos/square samples 3 clocks after each ce.
module nco_quad_gen (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [19:0] freq_word,
   input  logic        ce,
   input  logic        phase_sync,
   output logic [15:0] sin_out,
   output logic [15:0] cos_out,
   output logic        ref_sq,
   output logic        cycle_start,
   output logic        out_valid
);

   // round(32767*sin(pi*(2i+1)/256)), i = 0..63
   localparam logic [15:0] QTAB [0:63] = '{
      16'd402,   16'd1206,  16'd2009,  16'd2811,  16'd3612,  16'd4410,  16'd5205,  16'd5998,
      16'd6786,  16'd7571,  16'd8351,  16'd9126,  16'd9896,  16'd10659, 16'd11417, 16'd12167,
      16'd12910, 16'd13645, 16'd14372, 16'd15090, 16'd15800, 16'd16499, 16'd17189, 16'd17869,
      16'd18537, 16'd19195, 16'd19841, 16'd20475, 16'd21096, 16'd21705, 16'd22301, 16'd22884,
      16'd23452, 16'd24007, 16'd24547, 16'd25072, 16'd25582, 16'd26077, 16'd26556, 16'd27019,
      16'd27466, 16'd27896, 16'd28310, 16'd28706, 16'd29085, 16'd29447, 16'd29791, 16'd30117,
      16'd30424, 16'd30714, 16'd30985, 16'd31237, 16'd31470, 16'd31685, 16'd31880, 16'd32057,
      16'd32213, 16'd32351, 16'd32469, 16'd32567, 16'd32646, 16'd32705, 16'd32745, 16'd32765
   };

   logic [19:0] ph_q, ph_d;
   logic        wrap_q, wrap_d;
   logic [19:0] ph_base;
   logic        wrap_base;
   logic [20:0] ph_sum;

   logic [7:0]  p0_q;
   logic        cs0_q, v0_q;

   logic [1:0]  quad;
   logic [5:0]  idx, idx_mir;
   logic [5:0]  sin_addr1_q, cos_addr1_q;
   logic        sin_neg1_q, cos_neg1_q, ref1_q, cs1_q, v1_q;

   logic [15:0] sin_mag2_q, cos_mag2_q;
   logic        sin_neg2_q, cos_neg2_q, ref2_q, cs2_q, v2_q;

   logic [15:0] sin_q, cos_q;
   logic        ref_q, cycle_start_q, out_valid_q;

   // A sync in the same cycle as ce takes effect before the sample is taken.
   always_comb begin
      ph_base   = phase_sync ? 20'd0 : ph_q;
      wrap_base = phase_sync | wrap_q;
      ph_sum    = {1'b0, ph_base} + {1'b0, freq_word};
      ph_d      = ph_q;
      wrap_d    = wrap_q;
      if (ce) begin
         ph_d   = ph_sum[19:0];
         wrap_d = ph_sum[20];
      end else if (phase_sync) begin
         ph_d   = 20'd0;
         wrap_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ph_q   <= 20'd0;
         wrap_q <= 1'b0;
         cs0_q  <= 1'b0;
         v0_q   <= 1'b0;
         ref1_q <= 1'b0;
         cs1_q  <= 1'b0;
         v1_q   <= 1'b0;
         ref2_q <= 1'b0;
         cs2_q  <= 1'b0;
         v2_q   <= 1'b0;
      end else begin
         ph_q   <= ph_d;
         wrap_q <= wrap_d;
         v0_q   <= ce;
         if (ce) begin
            cs0_q <= wrap_base;
         end
         ref1_q <= p0_q[7];
         cs1_q  <= cs0_q;
         v1_q   <= v0_q;
         ref2_q <= ref1_q;
         cs2_q  <= cs1_q;
         v2_q   <= v1_q;
      end
   end

   assign quad    = p0_q[7:6];
   assign idx     = p0_q[5:0];
   assign idx_mir = 6'd63 - idx;

   // Datapath registers carry no reset so the ROM maps onto block RAM.
   always_ff @(posedge clk) begin
      if (ce) begin
         p0_q <= ph_base[19:12];
      end
      sin_addr1_q <= quad[0] ? idx_mir : idx;
      cos_addr1_q <= quad[0] ? idx : idx_mir;
      sin_neg1_q  <= quad[1];
      cos_neg1_q  <= quad[1] ^ quad[0];
      sin_mag2_q  <= QTAB[sin_addr1_q];
      cos_mag2_q  <= QTAB[cos_addr1_q];
      sin_neg2_q  <= sin_neg1_q;
      cos_neg2_q  <= cos_neg1_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sin_q         <= 16'd0;
         cos_q         <= 16'd0;
         ref_q         <= 1'b0;
         cycle_start_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         if (v2_q) begin
            sin_q <= sin_neg2_q ? (16'd0 - sin_mag2_q) : sin_mag2_q;
            cos_q <= cos_neg2_q ? (16'd0 - cos_mag2_q) : cos_mag2_q;
            ref_q <= ref2_q;
         end
         cycle_start_q <= v2_q & cs2_q;
         out_valid_q   <= v2_q;
      end
   end

   assign sin_out     = sin_q;
   assign cos_out     = cos_q;
   assign ref_sq      = ref_q;
   assign cycle_start = cycle_start_q;
   assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_nco_quad_gen.sv
// Scoreboard bench for nco_quad_gen: a behavioural phase model queues the
// expected sample for every ce, and the output monitor pops and compares.
module tb_nco_quad_gen;

   localparam real PI = 3.14159265358979;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [19:0] freq_word = 20'd0;
   logic        ce = 1'b0;
   logic        phase_sync = 1'b0;
   logic [15:0] sin_out, cos_out;
   logic        ref_sq, cycle_start, out_valid;

   nco_quad_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .freq_word   (freq_word),
      .ce          (ce),
      .phase_sync  (phase_sync),
      .sin_out     (sin_out),
      .cos_out     (cos_out),
      .ref_sq      (ref_sq),
      .cycle_start (cycle_start),
      .out_valid   (out_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] s;
      logic [15:0] c;
      logic        r;
      logic        cs;
      logic [19:0] ph;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic        mon_en = 1'b0;
   logic [19:0] ph_m = 20'd0;
   logic        wrap_m = 1'b0;
   logic [15:0] last_s = 16'd0, last_c = 16'd0;
   logic        last_r = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
      end
   endtask

   function automatic int tq(input int i);
      real r;
      r = 32767.0 * $sin(PI * real'(2 * i + 1) / 256.0);
      return $rtoi(r + 0.5);
   endfunction

   function automatic exp_t mk_exp(input logic [19:0] p, input logic cs);
      exp_t e;
      int   i, sv, cv;
      i = int'(p[17:12]);
      case (p[19:18])
         2'd0:    begin sv =  tq(i);      cv =  tq(63 - i); end
         2'd1:    begin sv =  tq(63 - i); cv = -tq(i);      end
         2'd2:    begin sv = -tq(i);      cv = -tq(63 - i); end
         default: begin sv = -tq(63 - i); cv =  tq(i);      end
      endcase
      e.s   = 16'(sv);
      e.c   = 16'(cv);
      e.r   = p[19];
      e.cs  = cs;
      e.ph  = p;
      e.due = 0;
      return e;
   endfunction

   // Drive one clock of stimulus; the model advances exactly as the DUT should.
   task automatic step(input logic ce_v, input logic sync_v, input logic [19:0] fw);
      logic [19:0] base;
      logic        wb;
      logic [20:0] sum;
      exp_t        e;
      ce         = ce_v;
      phase_sync = sync_v;
      freq_word  = fw;
      base = sync_v ? 20'd0 : ph_m;
      wb   = sync_v | wrap_m;
      if (ce_v) begin
         e     = mk_exp(base, wb);
         e.due = cyc + 4;
         sb.push_back(e);
         sum    = {1'b0, base} + {1'b0, fw};
         ph_m   = sum[19:0];
         wrap_m = sum[20];
      end else if (sync_v) begin
         ph_m   = 20'd0;
         wrap_m = 1'b1;
      end
      @(posedge clk);
      #1;
      ce         = 1'b0;
      phase_sync = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("cs_without_valid", {31'd0, cycle_start & ~out_valid}, 32'd0);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("spurious_valid", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               $display("sample cyc=%0d ph=%05h sin=%0d cos=%0d ref=%0b cs=%0b", cyc, e.ph,
                        $signed(sin_out), $signed(cos_out), ref_sq, cycle_start);
               chk("latency", cyc, e.due);
               chk("sin", {16'd0, sin_out}, {16'd0, e.s});
               chk("cos", {16'd0, cos_out}, {16'd0, e.c});
               chk("ref_sq", {31'd0, ref_sq}, {31'd0, e.r});
               chk("cycle_start", {31'd0, cycle_start}, {31'd0, e.cs});
               last_s = e.s;
               last_c = e.c;
               last_r = e.r;
            end
         end else begin
            chk("hold_sin", {16'd0, sin_out}, {16'd0, last_s});
            chk("hold_cos", {16'd0, cos_out}, {16'd0, last_c});
            chk("hold_ref", {31'd0, ref_sq}, {31'd0, last_r});
            if (sb.size() > 0 && sb[0].due <= cyc) begin
               chk("missing_valid", 32'd0, 32'd1);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_sin"}, {16'd0, sin_out}, 32'd0);
      chk({tag, "_cos"}, {16'd0, cos_out}, 32'd0);
      chk({tag, "_ref"}, {31'd0, ref_sq}, 32'd0);
      chk({tag, "_cs"}, {31'd0, cycle_start}, 32'd0);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // DC: phase stays at 0, first sample after reset has no cycle_start
      repeat (20) step(1'b1, 1'b0, 20'd0);

      // Quarter-turn steps: four-sample period, cycle_start from the 5th on
      repeat (16) step(1'b1, 1'b0, 20'h40000);

      // Minimum step at 1-in-8 strobes, then continuous until index 1 is reached
      step(1'b0, 1'b1, 20'h00001);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, 20'h00001);
         repeat (7) step(1'b0, 1'b0, 20'h00001);
      end
      repeat (4100) step(1'b1, 1'b0, 20'h00001);

      // Sync alone mid-run, then sync coincident with ce
      repeat (5) step(1'b1, 1'b0, 20'h40000);
      step(1'b0, 1'b1, 20'h40000);
      step(1'b0, 1'b0, 20'h40000);
      repeat (4) step(1'b1, 1'b0, 20'h40000);
      step(1'b1, 1'b1, 20'h40000);
      repeat (4) step(1'b1, 1'b0, 20'h40000);

      // One-cycle reset with three samples in flight
      repeat (3) step(1'b1, 1'b0, 20'h12345);
      reset_n = 1'b0;
      sb.delete();
      ph_m   = 20'd0;
      wrap_m = 1'b0;
      last_s = 16'd0;
      last_c = 16'd0;
      last_r = 1'b0;
      @(negedge clk);
      check_zero_outputs("midreset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (6) step(1'b0, 1'b0, 20'd0);

      // Frequency change on the third ce: phases 0,40000,80000,00000,80000
      repeat (2) step(1'b1, 1'b0, 20'h40000);
      repeat (3) step(1'b1, 1'b0, 20'h80000);
      repeat (4) step(1'b0, 1'b0, 20'h80000);

      // Random strobes, syncs and tuning words
      for (int k = 0; k < 300; k++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 20'($urandom));
      end

      repeat (8) step(1'b0, 1'b0, 20'd0);
      chk("drain_empty", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/nco_quad_gen.md
# nco_quad_gen

Numerically controlled oscillator that consumes the 20-bit frequency tuning word from the NCO frequency-control PIO register. It produces quadrature 16-bit sine/cosine references for one lock-in channel. The block sits between the Avalon PIO `out_port` and the lock-in demodulator multipliers. It advances phase once per sample strobe and delivers a pipelined, sample-aligned reference pair.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock, same domain as the PIO register.
- reset_n  in  1  asynchronous, active-low reset.
- freq_word  in  20  phase increment per `ce`, unsigned; f_out = f_ce·freq_word/2^20.
- ce  in  1  sample strobe; one phase step and one output sample per high cycle. Back-to-back highs are allowed.
- phase_sync  in  1  synchronous phase restart to 0; usable on any cycle.
- sin_out  out  16  signed two's-complement sine sample.
- cos_out  out  16  signed two's-complement cosine sample.
- ref_sq  out  1  square reference; the MSB of the sample phase.
- cycle_start  out  1  high with `out_valid` when this sample begins a new reference period.
- out_valid  out  1  one-cycle pulse per produced sample.

## Operation
- Phase accumulator `ph` is 20 bits and wraps modulo 2^20. On `ce`:
  - The sample phase `p` is the current `ph`.
  - `ph <= ph + freq_word`.
  - The carry-out is stored in `wrap_flag`; it marks the next sample.
- Sample phase `p` is pushed down the pipeline together with the current `wrap_flag`. `wrap_flag` is then overwritten with the new carry.
- phase_sync without ce: `ph <= 0`, `wrap_flag <= 1`. No sample is produced. The next ce therefore emits phase 0 with cycle_start=1.
- phase_sync with ce in the same cycle: the sync is applied first. The sample uses p=0 with cycle_start=1, and `ph <= freq_word`.
- Lookup uses quadrant `q = p[19:18]` and index `i = p[17:12]`. Bits p[11:0] are dropped; there is no interpolation.
- Quarter-wave ROM T[0..63]: T[i] = round(32767·sin(π(2i+1)/256)). T[0]=402, T[63]=32765. Values are stored as 16-bit unsigned constants.
- Sine by quadrant: q0 +T[i]; q1 +T[63−i]; q2 −T[i]; q3 −T[63−i].
- Cosine by quadrant: q0 +T[63−i]; q1 −T[i]; q2 −T[63−i]; q3 +T[i].
- Negation is plain two's complement. The magnitude is ≤32765, so negation never overflows and no saturation logic is required.
- ref_sq = p[19] of the same sample, and it holds between samples.
- sin_out, cos_out and ref_sq hold their last value until the next valid.
- cycle_start is only ever high while out_valid is high.
- freq_word is sampled directly on each ce and needs no extra synchronisation. A change affects the step taken at the first ce on or after the change.

## Timing
- Four-stage pipeline:
  - S0: accumulator and sample-phase capture, on the edge where ce=1.
  - S1: quadrant/index decode and mirrored address.
  - S2: registered ROM reads, one for sine and one for cosine.
  - S3: sign application and output registers.
- Latency: ce sampled at edge k gives sin_out/cos_out/ref_sq/cycle_start/out_valid updated at edge k+3. out_valid is high for exactly one cycle.
- Throughput: one sample per clock. The pipeline never stalls, and a ce on every cycle yields out_valid on every cycle.
- Reset values: ph=0, wrap_flag=0, all pipeline valids 0, sin_out=0, cos_out=0, ref_sq=0, cycle_start=0, out_valid=0.
- Reset asserted mid-pipeline discards in-flight samples. After release, no out_valid occurs before a new ce plus 3 edges.
- The first sample after reset has phase 0 and cycle_start=0. The sync flag is only set by phase_sync or by a carry.

## Test plan
- Reset, freq_word=0, ce held high:
  - out_valid rises 3 edges after the first ce edge and stays high.
  - sin_out=402 and cos_out=32765 constantly; ref_sq=0 and cycle_start=0.
- freq_word=0x40000, ce every cycle:
  - sin sequence 402, 32765, −402, −32765 repeats; cos sequence 32765, −402, −32765, 402.
  - ref_sq is 0,0,1,1.
  - cycle_start is high on every 4th sample, starting with the 5th.
- freq_word=0x00001 with ce strobed 1-in-8: exactly 8 clocks separate out_valid pulses. Outputs stay constant at 402/32765 until p[12] toggles after 4096 samples.
- phase_sync:
  - Pulse phase_sync alone mid-run with freq_word=0x40000. The next sample is 402/32765 with cycle_start=1.
  - Repeat with phase_sync and ce coincident. The same sample appears, and the following sample is 32765/−402.
- Drive freq_word=0x40000 for 2 ce, change to 0x80000 on the cycle of the 3rd ce:
  - Sample phases are 0, 0x40000, 0x80000, 0x00000, 0x80000.
  - cycle_start is set on the 4th sample.
- Assert reset_n low for 1 cycle while 3 samples are in flight. No out_valid appears from them, all outputs read 0, and the phase restarts at 0.
